// File: rtl/mdu_sequencer_if.sv
// Pipeline-side bundle for the multiply/divide sequencer: EXE issue, WB HI/LO moves, stall and HI/LO.
interface mdu_sequencer_if;
  logic [3:0]  EXE_MDUOp;
  logic [31:0] EXE_BusA;
  logic [31:0] EXE_BusB;
  logic        MDU_Cancel;
  logic        WB_HIWr;
  logic        WB_LOWr;
  logic [31:0] WB_OutB;
  logic        MDU_Busy;
  logic [31:0] MDU_HI;
  logic [31:0] MDU_LO;

  modport master (
    output EXE_MDUOp, EXE_BusA, EXE_BusB, MDU_Cancel, WB_HIWr, WB_LOWr, WB_OutB,
    input  MDU_Busy, MDU_HI, MDU_LO
  );

  modport slave (
    input  EXE_MDUOp, EXE_BusA, EXE_BusB, MDU_Cancel, WB_HIWr, WB_LOWr, WB_OutB,
    output MDU_Busy, MDU_HI, MDU_LO
  );
endinterface

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply / restoring-divide sequencer owning HI/LO; stalls the pipeline while working.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU (ops 5..8), which accumulate into HI/LO.
module mdu_sequencer #(
  parameter int MUL_CYCLES = 2
) (
  input logic            clk,
  input logic            rst,
  mdu_sequencer_if.slave bus
);
  localparam int DIV_STEPS = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state_r, state_nx_s;
  logic [4:0]  cnt_r;
  logic [31:0] op_a_r, op_b_r, quo_r, rem_r, hi_r, lo_r;
  logic [63:0] prod_r;
  logic        signed_r, div_r, acc_r, sub_r;

  logic        valid_op_s, op_signed_s, op_div_s, op_acc_s, op_sub_s;
  logic        start_s, commit_s, sign_a_s, sign_b_s;
  logic [31:0] a_mag_in_s, dvs_mag_s, q_fix_s, r_fix_s;
  logic [32:0] rem_sh_s, trial_s;
  logic [63:0] mul_a_s, mul_b_s, prod_s, result_s;

  // Decode the EXE op into class flags; the accumulate ops exist only in the MADD build.
  always_comb begin
    valid_op_s  = 1'b0;
    op_signed_s = 1'b0;
    op_div_s    = 1'b0;
    op_acc_s    = 1'b0;
    op_sub_s    = 1'b0;
    case (bus.EXE_MDUOp)
      4'd1: begin valid_op_s = 1'b1; op_signed_s = 1'b1; end
      4'd2: valid_op_s = 1'b1;
      4'd3: begin valid_op_s = 1'b1; op_signed_s = 1'b1; op_div_s = 1'b1; end
      4'd4: begin valid_op_s = 1'b1; op_div_s = 1'b1; end
`ifdef MDU_MADD_EN
      4'd5: begin valid_op_s = 1'b1; op_signed_s = 1'b1; op_acc_s = 1'b1; end
      4'd6: begin valid_op_s = 1'b1; op_acc_s = 1'b1; end
      4'd7: begin valid_op_s = 1'b1; op_signed_s = 1'b1; op_acc_s = 1'b1; op_sub_s = 1'b1; end
      4'd8: begin valid_op_s = 1'b1; op_acc_s = 1'b1; op_sub_s = 1'b1; end
`else
      4'd5, 4'd6, 4'd7, 4'd8: valid_op_s = 1'b0;
`endif
      default: valid_op_s = 1'b0;
    endcase
  end

  assign a_mag_in_s = (op_signed_s && bus.EXE_BusA[31]) ? (32'd0 - bus.EXE_BusA) : bus.EXE_BusA;
  assign sign_a_s   = signed_r & op_a_r[31];
  assign sign_b_s   = signed_r & op_b_r[31];
  assign dvs_mag_s  = sign_b_s ? (32'd0 - op_b_r) : op_b_r;

  // Low 64 bits of the 33x33 signed product equal the product of the 64-bit sign extensions.
  assign mul_a_s = {{32{sign_a_s}}, op_a_r};
  assign mul_b_s = {{32{sign_b_s}}, op_b_r};
  assign prod_s  = mul_a_s * mul_b_s;

  assign rem_sh_s = {rem_r, quo_r[31]};
  assign trial_s  = rem_sh_s - {1'b0, dvs_mag_s};
  assign q_fix_s  = (sign_a_s ^ sign_b_s) ? (32'd0 - quo_r) : quo_r;
  assign r_fix_s  = sign_a_s ? (32'd0 - rem_r) : rem_r;

  // Value committed to {HI,LO} in DONE.
  always_comb begin
    result_s = prod_r;
    if (div_r) begin
      result_s = {r_fix_s, q_fix_s};
    end else if (acc_r && sub_r) begin
      result_s = {hi_r, lo_r} - prod_r;
    end else if (acc_r) begin
      result_s = {hi_r, lo_r} + prod_r;
    end else begin
      result_s = prod_r;
    end
  end

  // Next-state logic; a cancel pulls any active state back to IDLE.
  always_comb begin
    state_nx_s = state_r;
    start_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (valid_op_s && !bus.MDU_Cancel) begin
          start_s    = 1'b1;
          state_nx_s = op_div_s ? ST_DIV : ST_MUL;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (bus.MDU_Cancel) begin
          state_nx_s = ST_IDLE;
        end else if (cnt_r == 5'd0) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  assign commit_s     = (state_r == ST_DONE) && !bus.MDU_Cancel;
  assign bus.MDU_Busy = start_s | (((state_r == ST_MUL) || (state_r == ST_DIV)) && !bus.MDU_Cancel);
  assign bus.MDU_HI   = hi_r;
  assign bus.MDU_LO   = lo_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Operand capture, iteration datapath and HI/LO ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= 5'd0;
      op_a_r   <= 32'd0;
      op_b_r   <= 32'd0;
      quo_r    <= 32'd0;
      rem_r    <= 32'd0;
      prod_r   <= 64'd0;
      signed_r <= 1'b0;
      div_r    <= 1'b0;
      acc_r    <= 1'b0;
      sub_r    <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
    end else begin
      if (start_s) begin
        op_a_r   <= bus.EXE_BusA;
        op_b_r   <= bus.EXE_BusB;
        signed_r <= op_signed_s;
        div_r    <= op_div_s;
        acc_r    <= op_acc_s;
        sub_r    <= op_sub_s;
        quo_r    <= a_mag_in_s;
        rem_r    <= 32'd0;
        cnt_r    <= op_div_s ? 5'(DIV_STEPS - 1) : 5'(MUL_CYCLES - 1);
      end else if (state_r == ST_MUL) begin
        cnt_r <= cnt_r - 5'd1;
        if (cnt_r == 5'd0) begin
          prod_r <= prod_s;
        end
      end else if (state_r == ST_DIV) begin
        cnt_r <= cnt_r - 5'd1;
        quo_r <= {quo_r[30:0], ~trial_s[32]};
        rem_r <= trial_s[32] ? rem_sh_s[31:0] : trial_s[31:0];
      end

      // The finishing mult/div is younger than any MTHI/MTLO in WB, so it wins the cycle.
      if (commit_s) begin
        {hi_r, lo_r} <= result_s;
      end else begin
        if (bus.WB_HIWr) begin
          hi_r <= bus.WB_OutB;
        end
        if (bus.WB_LOWr) begin
          lo_r <= bus.WB_OutB;
        end
      end
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed cases plus randomized ops against an arithmetic model.
module tb_mdu_sequencer;
  localparam int MUL_CYCLES = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_sequencer_if mif ();
  mdu_sequencer #(.MUL_CYCLES(MUL_CYCLES)) dut (.clk(clk), .rst(rst), .bus(mif));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
    int          id;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          n_ops = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  function automatic void chk(input string name, input int id, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s op#%0d: got %0h, required %0h", name, id, act, req);
    end
  endfunction

  function automatic bit op_valid(input int op);
`ifdef MDU_MADD_EN
    return (op >= 1) && (op <= 8);
`else
    return (op >= 1) && (op <= 4);
`endif
  endfunction

  // Reference result {HI,LO} from plain arithmetic.
  function automatic logic [63:0] ref_mdu(input int op, input logic [31:0] a, input logic [31:0] b,
                                          input logic [63:0] hilo);
    bit          sgn;
    bit          sa, sb;
    logic [31:0] ma, mb, q, r;
    logic [63:0] p;
    longint      a64, b64;
    sgn = (op == 1) || (op == 3) || (op == 5) || (op == 7);
    if ((op == 3) || (op == 4)) begin
      sa = sgn && a[31];
      sb = sgn && b[31];
      ma = sa ? (32'd0 - a) : a;
      mb = sb ? (32'd0 - b) : b;
      if (mb == 32'd0) begin
        q = 32'hFFFF_FFFF;
        r = ma;
      end else begin
        q = ma / mb;
        r = ma % mb;
      end
      if (sa ^ sb) q = 32'd0 - q;
      if (sa) r = 32'd0 - r;
      return {r, q};
    end
    if (sgn) begin
      a64 = longint'($signed(a));
      b64 = longint'($signed(b));
      p   = a64 * b64;
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    case (op)
      5, 6:    return hilo + p;
      7, 8:    return hilo - p;
      default: return p;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  task automatic idle_inputs();
    mif.EXE_MDUOp  = 4'd0;
    mif.EXE_BusA   = 32'd0;
    mif.EXE_BusB   = 32'd0;
    mif.MDU_Cancel = 1'b0;
    mif.WB_HIWr    = 1'b0;
    mif.WB_LOWr    = 1'b0;
    mif.WB_OutB    = 32'd0;
  endtask

  // cmode: 0 run to completion, 1 cancel after ck busy cycles, 2 cancel in DONE, 3 cancel in IDLE.
  // wbsel bit0/bit1: MTHI/MTLO in the issue cycle; coll: MTHI in the DONE cycle.
  task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b, input int cmode,
                       input int ck, input bit coll, input int wbsel, input logic [31:0] wbd);
    exp_t        e;
    logic [63:0] res;
    int          n;
    int          len;
    @(negedge clk);
    n_ops++;
    mif.EXE_MDUOp = 4'(op);
    mif.EXE_BusA  = a;
    mif.EXE_BusB  = b;
    mif.WB_HIWr   = wbsel[0];
    mif.WB_LOWr   = wbsel[1];
    mif.WB_OutB   = wbd;
    if (wbsel[0]) m_hi = wbd;
    if (wbsel[1]) m_lo = wbd;
    if (!op_valid(op) || (cmode == 3)) begin
      mif.MDU_Cancel = (cmode == 3);
      #1;
      chk("nostart_busy", n_ops, 64'(mif.MDU_Busy), 64'd0);
      @(negedge clk);
      idle_inputs();
      #1;
      chk("nostart_hi", n_ops, 64'(mif.MDU_HI), 64'(m_hi));
      chk("nostart_lo", n_ops, 64'(mif.MDU_LO), 64'(m_lo));
      return;
    end
    len  = ((op == 3) || (op == 4)) ? 33 : 1 + MUL_CYCLES;
    res  = ref_mdu(op, a, b, {m_hi, m_lo});
    e.id = n_ops;
    e.len = (cmode == 1) ? ck : len;
    if (cmode == 0) {m_hi, m_lo} = res;
    e.hi = m_hi;
    e.lo = m_lo;
    sb_q.push_back(e);
    n = 1;
    while (1) begin
      @(negedge clk);
      mif.WB_HIWr = 1'b0;
      mif.WB_LOWr = 1'b0;
      if ((cmode == 1) && (n == ck)) mif.MDU_Cancel = 1'b1;
      #1;
      if (!mif.MDU_Busy) break;
      n++;
      if (n > 80) begin
        vectors++;
        miscompares++;
        $display("FAIL busy_timeout op#%0d: busy still high after %0d cycles, required %0d", n_ops, n, e.len);
        break;
      end
    end
    // The instruction is still held in EXE here (DONE) and must not restart.
    if (cmode == 2) mif.MDU_Cancel = 1'b1;
    if (coll && (cmode == 0)) begin
      mif.WB_HIWr = 1'b1;
      mif.WB_OutB = 32'h0000_1234;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic mt_write(input bit hi_en, input bit lo_en, input logic [31:0] d);
    @(negedge clk);
    mif.WB_HIWr = hi_en;
    mif.WB_LOWr = lo_en;
    mif.WB_OutB = d;
    if (hi_en) m_hi = d;
    if (lo_en) m_lo = d;
    @(negedge clk);
    idle_inputs();
    #1;
    chk("mt_hi", 0, 64'(mif.MDU_HI), 64'(m_hi));
    chk("mt_lo", 0, 64'(mif.MDU_LO), 64'(m_lo));
  endtask

  task automatic expect_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
    #1;
    chk({name, "_hi"}, n_ops, 64'(mif.MDU_HI), 64'(hi));
    chk({name, "_lo"}, n_ops, 64'(mif.MDU_LO), 64'(lo));
  endtask

  // Monitor: each busy run ends in a DONE/cancel cycle; HI/LO are checked one cycle later.
  initial begin
    bit   prev_busy = 1'b0;
    bit   pend = 1'b0;
    int   run = 0;
    int   seen = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (pend) begin
        pend = 1'b0;
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_busy_run: got run of %0d cycles, required none", seen);
        end else begin
          e = sb_q.pop_front();
          chk("busy_len", e.id, 64'(seen), 64'(e.len));
          chk("result_hi", e.id, 64'(mif.MDU_HI), 64'(e.hi));
          chk("result_lo", e.id, 64'(mif.MDU_LO), 64'(e.lo));
        end
      end
      if (mif.MDU_Busy) begin
        run++;
      end else if (prev_busy) begin
        pend = 1'b1;
        seen = run;
        run  = 0;
      end
      prev_busy = mif.MDU_Busy;
    end
  end

  initial begin
    int op, cmode, ck, len, r, wbsel;
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", 0, 64'(mif.MDU_Busy), 64'd0);
    chk("reset_hi", 0, 64'(mif.MDU_HI), 64'd0);
    chk("reset_lo", 0, 64'(mif.MDU_LO), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    issue(1, 32'hFFFF_FFFE, 32'd3, 0, 0, 1'b0, 0, 32'd0);
    expect_hilo("mult_neg2x3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    issue(4, 32'd100, 32'd7, 0, 0, 1'b0, 0, 32'd0);
    expect_hilo("divu_100_7", 32'd2, 32'd14);
    issue(3, 32'hFFFF_FFF9, 32'd2, 0, 0, 1'b0, 0, 32'd0);
    expect_hilo("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(4, 32'd5, 32'd0, 0, 0, 1'b0, 0, 32'd0);
    expect_hilo("divu_by0", 32'd5, 32'hFFFF_FFFF);
    issue(3, 32'd1000, 32'd3, 1, 10, 1'b0, 0, 32'd0);
    expect_hilo("div_cancel", 32'd5, 32'hFFFF_FFFF);
    issue(2, 32'h0001_0000, 32'h0001_0000, 0, 0, 1'b1, 0, 32'd0);
    expect_hilo("done_vs_mthi", 32'd1, 32'd0);
    mt_write(1'b1, 1'b0, 32'd0);
    mt_write(1'b0, 1'b1, 32'hFFFF_FFFF);
    issue(6, 32'd1, 32'd1, 0, 0, 1'b0, 0, 32'd0);
`ifdef MDU_MADD_EN
    expect_hilo("maddu_1x1", 32'd1, 32'd0);
`else
    expect_hilo("maddu_off", 32'd0, 32'hFFFF_FFFF);
`endif
    issue(1, 32'd7, 32'd9, 3, 0, 1'b0, 0, 32'd0);
    issue(9, 32'd7, 32'd9, 0, 0, 1'b0, 0, 32'd0);
    issue(15, 32'd7, 32'd9, 0, 0, 1'b0, 0, 32'd0);
    issue(1, 32'd7, 32'd9, 2, 0, 1'b0, 0, 32'd0);

    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 12);
      len = ((op == 3) || (op == 4)) ? 33 : 1 + MUL_CYCLES;
      r = $urandom_range(0, 9);
      cmode = (r <= 6) ? 0 : r - 6;
      ck = $urandom_range(1, len - 1);
      wbsel = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      issue(op, pick(), pick(), cmode, ck, ($urandom_range(0, 4) == 0), wbsel, $urandom());
      if ($urandom_range(0, 7) == 0) mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom());
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 0, 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
